// File: rtl/event_tx_scheduler.sv
// Event-to-UART frame scheduler: arbitrates four event sources and
// sequences a 6-byte snapshot frame through the UART start/busy handshake.
module event_tx_scheduler #(
  parameter int          MSG_LEN     = 6,
  parameter int          ACK_TIMEOUT = 64,
  parameter int          TO_BIT      = 7,
  parameter logic [3:0]  HDR         = 4'hA
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw,
  input  logic       lev,
  input  logic       status,
  input  logic       history,
  input  logic       change,
  input  logic [3:0] o_min,
  input  logic [3:0] o_dmin,
  input  logic [3:0] o_ore,
  input  logic [3:0] o_dore,
  input  logic [8:0] livello,
  input  logic [6:0] cntL,
  input  logic       clr_flags,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       o_busy,
  output logic [2:0] o_code,
  output logic       msg_done,
  output logic [3:0] o_overrun,
  output logic       o_err
);

  typedef enum logic [2:0] {
    IDLE, LOAD, SEND, WAIT_ACK, WAIT_DONE, NEXT, DONE
  } state_t;

  state_t            state;
  logic [3:0]        src, src_q, req, pend, gnt, gmask;
  logic [2:0]        code_n, idx;
  logic              take;
  logic [TO_BIT-1:0] to_cnt;
  logic [7:0]        frame [MSG_LEN];
  logic [7:0]        b0, b1, b2, b3, b4;

  // bit order everywhere: {lev, status, history, change}
  assign src = {lev, status, history, change};
  assign req = src & ~src_q;

  always_comb begin
    gnt    = 4'b0000;
    code_n = 3'd0;
    if (pend[3]) begin
      gnt    = 4'b1000;
      code_n = 3'd1;
    end else if (pend[2]) begin
      gnt    = 4'b0100;
      code_n = 3'd3;
    end else if (pend[1]) begin
      gnt    = 4'b0010;
      code_n = 3'd6;
    end else if (pend[0]) begin
      gnt    = 4'b0001;
      code_n = 3'd2;
    end
  end

  assign take  = (state == IDLE) && sw && (|pend);
  assign gmask = take ? gnt : 4'b0000;

  assign b0 = {HDR, 1'b0, code_n};
  assign b1 = {o_dore, o_ore};
  assign b2 = {o_dmin, o_min};
  assign b3 = livello[7:0];
  assign b4 = {livello[8], cntL};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      src_q     <= '0;
      pend      <= '0;
      idx       <= '0;
      to_cnt    <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      o_busy    <= 1'b0;
      o_code    <= '0;
      msg_done  <= 1'b0;
      o_overrun <= '0;
      o_err     <= 1'b0;
      for (int i = 0; i < MSG_LEN; i++) frame[i] <= '0;
    end else begin
      src_q     <= src;
      pend      <= (pend & ~gmask) | req;
      o_overrun <= (clr_flags ? 4'b0000 : o_overrun)
                 | (req & pend & ~gmask);
      tx_start  <= 1'b0;
      msg_done  <= 1'b0;
      if (clr_flags) o_err <= 1'b0;

      unique case (state)
        IDLE: begin
          if (take) begin
            frame[0] <= b0;
            frame[1] <= b1;
            frame[2] <= b2;
            frame[3] <= b3;
            frame[4] <= b4;
            frame[5] <= b0 ^ b1 ^ b2 ^ b3 ^ b4;
            o_busy   <= 1'b1;
            o_code   <= code_n;
            state    <= LOAD;
          end
        end
        LOAD: begin
          idx   <= '0;
          state <= SEND;
        end
        SEND: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            tx_data  <= frame[idx];
            to_cnt   <= '0;
            state    <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (to_cnt == TO_BIT'(ACK_TIMEOUT - 1)) begin
            o_err  <= 1'b1;
            o_busy <= 1'b0;
            o_code <= '0;
            state  <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) state <= NEXT;
        end
        NEXT: begin
          if (idx == 3'(MSG_LEN - 1)) begin
            msg_done <= 1'b1;
            o_busy   <= 1'b0;
            o_code   <= '0;
            state    <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= SEND;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_event_tx_scheduler.sv
// Scoreboard bench for event_tx_scheduler: expected frame bytes are queued
// by the stimulus and popped by a monitor on every tx_start.
module tb_event_tx_scheduler;

  logic       clk = 1'b0;
  logic       rst, sw, lev, status, history, change;
  logic [3:0] o_min, o_dmin, o_ore, o_dore;
  logic [8:0] livello;
  logic [6:0] cntL;
  logic       clr_flags, tx_busy;
  logic       tx_start, o_busy, msg_done, o_err;
  logic [7:0] tx_data;
  logic [2:0] o_code;
  logic [3:0] o_overrun;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_start = 0;
  int   n_done  = 0;
  bit   stuck   = 1'b0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  event_tx_scheduler dut (
    .clk(clk), .rst(rst), .sw(sw),
    .lev(lev), .status(status), .history(history), .change(change),
    .o_min(o_min), .o_dmin(o_dmin), .o_ore(o_ore), .o_dore(o_dore),
    .livello(livello), .cntL(cntL), .clr_flags(clr_flags),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .o_busy(o_busy), .o_code(o_code), .msg_done(msg_done),
    .o_overrun(o_overrun), .o_err(o_err)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // UART: busy rises 2 cycles after start and stays high 20 cycles
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && !stuck) begin
        repeat (2) @(negedge clk);
        tx_busy = 1'b1;
        repeat (20) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  end

  // monitor
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start) begin
        n_start++;
        if (exp_q.size() == 0) begin
          check("unexpected_tx_start", {24'h0, tx_data}, 32'hFFFF_FFFF);
        end else begin
          check("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
        end
      end
      if (msg_done) n_done++;
    end
  end

  task automatic push_frame(logic [2:0] code);
    logic [7:0] b [6];
    b[0] = {4'hA, 1'b0, code};
    b[1] = {o_dore, o_ore};
    b[2] = {o_dmin, o_min};
    b[3] = livello[7:0];
    b[4] = {livello[8], cntL};
    b[5] = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4];
    for (int i = 0; i < 6; i++) exp_q.push_back(b[i]);
  endtask

  task automatic wait_done(int n, int budget, string name);
    int target = n_done + n;
    int k = 0;
    while (n_done < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, (n_done >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  int s0, d0, k;

  initial begin
    rst = 1'b1; sw = 1'b1;
    lev = 0; status = 0; history = 0; change = 0;
    o_dore = 4'd1; o_ore = 4'd2; o_dmin = 4'd3; o_min = 4'd4;
    livello = 9'h105; cntL = 7'd3; clr_flags = 0;
    cycles(3);
    check("reset_outputs",
          {tx_start, tx_data, o_busy, o_code, msg_done, o_overrun, o_err},
          32'd0);
    rst = 1'b0;
    cycles(2);

    // single lev frame, hand-computed bytes
    s0 = n_start; d0 = n_done;
    exp_q.push_back(8'hA1); exp_q.push_back(8'h12);
    exp_q.push_back(8'h34); exp_q.push_back(8'h05);
    exp_q.push_back(8'h83); exp_q.push_back(8'h01);
    lev = 1;
    cycles(1);
    check("lev_busy_not_yet", {31'd0, o_busy}, 32'd0);
    cycles(1);
    check("lev_busy", {31'd0, o_busy}, 32'd1);
    check("lev_code", {29'd0, o_code}, 32'd1);
    lev = 0;
    wait_done(1, 400, "lev_done_timeout");
    check("lev_starts", n_start - s0, 32'd6);
    check("lev_done_cnt", n_done - d0, 32'd1);
    check("lev_overrun", {28'd0, o_overrun}, 32'd0);
    check("lev_queue_empty", exp_q.size(), 32'd0);

    // lev + change together: lev first
    livello = 9'h0F0; cntL = 7'd77;
    push_frame(3'd1);
    push_frame(3'd2);
    lev = 1; change = 1;
    cycles(1);
    lev = 0; change = 0;
    wait_done(2, 800, "pair_done_timeout");
    check("pair_overrun", {28'd0, o_overrun}, 32'd0);
    check("pair_queue_empty", exp_q.size(), 32'd0);

    // sw=0 holds off grants
    sw = 0;
    s0 = n_start;
    o_min = 4'd9; o_dore = 4'd2;
    status = 1;
    cycles(1);
    status = 0;
    cycles(50);
    check("sw0_no_start", n_start - s0, 32'd0);
    check("sw0_not_busy", {31'd0, o_busy}, 32'd0);
    push_frame(3'd3);
    sw = 1;
    wait_done(1, 400, "status_done_timeout");
    check("status_queue_empty", exp_q.size(), 32'd0);

    // history twice during lev frame -> overrun, one history frame
    push_frame(3'd1);
    push_frame(3'd6);
    lev = 1;
    cycles(3);
    lev = 0;
    history = 1; cycles(1); history = 0; cycles(2);
    history = 1; cycles(1); history = 0;
    cycles(1);
    check("hist_overrun", {28'd0, o_overrun}, 32'h2);
    wait_done(2, 800, "hist_done_timeout");
    check("hist_queue_empty", exp_q.size(), 32'd0);
    cycles(20);
    check("hist_no_extra", exp_q.size(), 32'd0);
    clr_flags = 1; cycles(1); clr_flags = 0;
    check("hist_clr", {28'd0, o_overrun}, 32'd0);

    // ack timeout
    stuck = 1;
    s0 = n_start; d0 = n_done;
    exp_q.push_back({4'hA, 1'b0, 3'd1});
    lev = 1; cycles(1); lev = 0;
    k = 0;
    while (!o_err && k < 200) begin
      cycles(1);
      k++;
    end
    check("to_err", {31'd0, o_err}, 32'd1);
    check("to_not_busy", {31'd0, o_busy}, 32'd0);
    check("to_no_done", n_done - d0, 32'd0);
    check("to_one_start", n_start - s0, 32'd1);
    check("to_latency_min", (k >= 60) ? 32'd1 : 32'd0, 32'd1);
    stuck = 0;
    cycles(3);
    push_frame(3'd1);
    lev = 1; cycles(1); lev = 0;
    wait_done(1, 400, "after_to_done_timeout");
    check("after_to_queue_empty", exp_q.size(), 32'd0);
    clr_flags = 1; cycles(1); clr_flags = 0;
    check("err_clr", {31'd0, o_err}, 32'd0);

    // reset mid-frame; pending status lost
    s0 = n_start;
    push_frame(3'd1);
    lev = 1; cycles(1); lev = 0;
    status = 1; cycles(1); status = 0;
    k = 0;
    while (n_start < s0 + 4 && k < 400) begin
      cycles(1);
      k++;
    end
    check("rst_reached_b3", n_start - s0, 32'd4);
    cycles(3);
    rst = 1;
    cycles(1);
    check("rst_outputs",
          {tx_start, tx_data, o_busy, o_code, msg_done, o_overrun, o_err},
          32'd0);
    rst = 0;
    exp_q.delete();
    s0 = n_start;
    cycles(120);
    check("rst_no_start", n_start - s0, 32'd0);
    check("rst_not_busy", {31'd0, o_busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
